// File: rtl/program_counter.sv
// program_counter: fetch-stage PC with IDLE/RUN/DONE run control.
// Build with PC_INSTR_COUNT_EN defined to include the retired-instruction counter;
// without it instr_count is tied to zero.
module program_counter #(
    parameter logic [31:0] START_ADDR = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        halt_req,
    input  logic        stall,
    input  logic        jump_en,
    input  logic        jump_absolute,
    input  logic [31:0] jump_target,
    input  logic [7:0]  jump_offset,
    output logic [31:0] current_pc,
    output logic        running,
    output logic        done,
    output logic [31:0] instr_count
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] offset_ext;
    logic        advance;
    logic        restart;

    assign offset_ext = {{24{jump_offset[7]}}, jump_offset};
    assign advance    = (state == RUN) && !halt_req && !stall;
    assign restart    = (state != RUN) && start;

    // Run-controller state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state: halt ends a run, start (re)launches from IDLE or DONE.
    always_comb begin
        state_nxt = (state == RUN) ? (halt_req ? DONE : RUN) : (start ? RUN : state);
    end

    // Status outputs decode the registered state only.
    always_comb begin
        running = (state == RUN);
        done    = (state == DONE);
    end

    // Next PC: restart load, otherwise jump/branch/increment unless halted or stalled.
    always_comb begin
        pc_nxt = restart ? START_ADDR
               : !advance ? current_pc
               : !jump_en ? current_pc + 32'd1
               : jump_absolute ? jump_target
               : current_pc + offset_ext;
    end

    // PC register feeding the instruction memory.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            current_pc <= 32'd0;
        else
            current_pc <= pc_nxt;
    end

`ifdef PC_INSTR_COUNT_EN
    // Retired-instruction counter: counts unstalled RUN edges (halting edge included), saturating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            instr_count <= 32'd0;
        else if (restart)
            instr_count <= 32'd0;
        else if (state == RUN && !stall && instr_count != 32'hFFFF_FFFF)
            instr_count <= instr_count + 32'd1;
    end
`else
    assign instr_count = 32'd0;
`endif
endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: scoreboard bench for program_counter.
module tb_program_counter;
    localparam logic [31:0] START = 32'd0;
`ifdef PC_INSTR_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        halt_req = 1'b0;
    logic        stall = 1'b0;
    logic        jump_en = 1'b0;
    logic        jump_absolute = 1'b0;
    logic [31:0] jump_target = 32'd0;
    logic [7:0]  jump_offset = 8'd0;
    logic [31:0] current_pc;
    logic        running;
    logic        done;
    logic [31:0] instr_count;

    typedef struct {
        logic [31:0] pc;
        logic        run;
        logic        dn;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          m_state = 0;
    logic [31:0] m_pc = 32'd0;
    logic [31:0] m_cnt = 32'd0;

    program_counter #(.START_ADDR(START)) dut (
        .clk(clk), .reset(reset), .start(start), .halt_req(halt_req), .stall(stall),
        .jump_en(jump_en), .jump_absolute(jump_absolute), .jump_target(jump_target),
        .jump_offset(jump_offset), .current_pc(current_pc), .running(running),
        .done(done), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic push_model();
        sb.push_back('{m_pc, m_state == 1, m_state == 2, m_cnt});
    endtask

    task automatic compare(input string tag);
        exp_t e;
        e = sb.pop_front();
        check({tag, ".pc"}, current_pc, e.pc);
        check({tag, ".running"}, {31'd0, running}, {31'd0, e.run});
        check({tag, ".done"}, {31'd0, done}, {31'd0, e.dn});
        check({tag, ".count"}, instr_count, e.cnt);
    endtask

    task automatic drive(input string tag, input logic st, input logic hr, input logic sl,
                         input logic je, input logic ja, input logic [31:0] tg, input logic [7:0] off);
        start = st; halt_req = hr; stall = sl; jump_en = je; jump_absolute = ja;
        jump_target = tg; jump_offset = off;
        if (m_state != 1) begin
            if (st) begin
                m_state = 1;
                m_pc = START;
                m_cnt = 32'd0;
            end
        end else begin
            if (!sl && CNT_EN && m_cnt != 32'hFFFF_FFFF)
                m_cnt = m_cnt + 32'd1;
            if (hr)
                m_state = 2;
            else if (!sl) begin
                if (!je)
                    m_pc = m_pc + 32'd1;
                else if (ja)
                    m_pc = tg;
                else if (off[7])
                    m_pc = m_pc - (32'd256 - {24'd0, off});
                else
                    m_pc = m_pc + {24'd0, off};
            end
        end
        push_model();
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    task automatic idle_step(input string tag);
        drive(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0);
    endtask

    task automatic jump_abs(input string tag, input logic [31:0] tg);
        drive(tag, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, tg, 8'd0);
    endtask

    task automatic jump_rel(input string tag, input logic [7:0] off);
        drive(tag, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, off);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        push_model();
        compare("reset");
        reset = 1'b0;
        drive("idle_ignores_jump", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h55, 8'd0);
        drive("start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0);
        for (int i = 0; i < 5; i++) idle_step("inc");
        for (int i = 0; i < 3; i++)
            drive("stall_jump", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h99, 8'd0);
        idle_step("after_stall");
        idle_step("inc7");
        drive("halt_stall", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 8'd0);
        idle_step("done_hold");
        drive("restart", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0);
        jump_abs("abs_10", 32'h10);
        jump_rel("rel_m5", 8'hFB);
        jump_abs("abs_200", 32'h200);
        jump_rel("rel_p7f", 8'h7F);
        jump_rel("rel_m80", 8'h80);
        jump_abs("abs_max", 32'hFFFF_FFFF);
        idle_step("wrap_inc");
        jump_rel("wrap_neg", 8'hFF);
        drive("start_in_run", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0);
        drive("halt", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0);
        drive("restart2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0);
        jump_abs("abs_42", 32'h42);
        #2;
        reset = 1'b1;
        m_state = 0;
        m_pc = 32'd0;
        m_cnt = 32'd0;
        #1;
        push_model();
        compare("async_reset");
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        push_model();
        compare("post_reset_idle");
        drive("start_after_reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0);
        idle_step("inc_after_reset");
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/program_counter.md
# program_counter

Fetch-stage program counter driving `current_pc` into the 9-bit instruction memory. Holds the PC and a three-state run controller (IDLE, RUN, DONE). Sequences the PC by increment, absolute jump or PC-relative branch under stall and halt control. Provides start/done handshaking to the testbench or top level and an optional retired-instruction counter.

## Interface
- `START_ADDR`, default 0: PC value loaded on `start`.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `start` input 1: begin execution; honoured only in IDLE or DONE.
- `halt_req` input 1: decoded halt instruction; ends execution.
- `stall` input 1: hold the PC this cycle.
- `jump_en` input 1: take a control transfer this cycle.
- `jump_absolute` input 1: 1 = load `jump_target`; 0 = relative by `jump_offset`.
- `jump_target` input 32: absolute target address.
- `jump_offset` input 8: signed two's-complement offset, relative to `current_pc`.
- `current_pc` output 32: registered PC to instruction memory.
- `running` output 1: high in RUN.
- `done` output 1: high in DONE.
- `instr_count` output 32: retired-instruction count (see Configuration).

## Operation
- Reset values: state IDLE, `current_pc` = 0, `running` = 0, `done` = 0, `instr_count` = 0.
- IDLE:
  - `start` = 1 → RUN, PC <= `START_ADDR`, `instr_count` <= 0.
  - Other inputs are ignored.
- RUN: next-PC priority, highest first:
  - `halt_req` → DONE, PC holds.
  - `stall` → PC holds.
  - `jump_en` and `jump_absolute` → PC <= `jump_target`.
  - `jump_en` and not `jump_absolute` → PC <= `current_pc` + sign_extend(`jump_offset`).
  - otherwise PC <= `current_pc` + 1.
  - `start` in RUN is ignored.
- DONE:
  - PC holds its value and `done` = 1.
  - `start` = 1 → RUN, PC <= `START_ADDR`, `instr_count` <= 0.
- Arithmetic:
  - All PC arithmetic is 32-bit modulo 2^32; 0xFFFFFFFF + 1 wraps to 0.
  - A negative offset below 0 wraps the same way.
  - The offset is sign-extended from bit 7; range −128..+127.
- Simultaneous `halt_req` and `stall`: halt wins; the design enters DONE.
- Simultaneous `stall` and `jump_en`: the jump is dropped. Upstream must hold `jump_en` until `stall` deasserts.
- Reset asserted mid-RUN: IDLE and all outputs at reset values immediately, without waiting for a clock edge.

## Timing
- `current_pc` comes straight from a flop. The instruction memory read is combinational, so the instruction for `current_pc` is valid in the same cycle.
- Control inputs are sampled at the rising edge and take effect on the PC in the next cycle: one cycle of latency.
- `start` to first valid PC: 1 cycle. `running` rises on the same edge.
- `halt_req` to `done`: 1 cycle. `running` falls on the same edge.
- No combinational path from any input to any output.

## Configuration
- `PC_INSTR_COUNT_EN` defined:
  - `instr_count` increments by 1 on each RUN-state edge with `stall` = 0, including the halting edge.
  - It saturates at 0xFFFFFFFF, holds in IDLE and DONE, and is cleared on `start`.
- `PC_INSTR_COUNT_EN` undefined:
  - The counter logic is not built and `instr_count` is tied to 0.
  - All other behaviour is identical.

## Test plan
- Reset, then `start` with `START_ADDR` = 0; no other inputs for 5 cycles → PC 0,1,2,3,4,5; `running` = 1; `instr_count` = 5 (with EN).
- At PC 0x10 apply `jump_en` = 1, `jump_absolute` = 0, `jump_offset` = 0xFB (−5) → next PC 0x0B. At PC 0x0B apply `jump_absolute` = 1, `jump_target` = 0x200 → next PC 0x200.
- At PC 5 apply `stall` for 3 cycles with `jump_en` = 1 → PC stays 5 throughout, then 6 after `stall` drops with `jump_en` = 0. `instr_count` does not advance during the stall.
- `halt_req` at PC 7 with `stall` = 1 → `done` = 1 and `running` = 0 next cycle; PC stays 7. `start` in DONE → PC = `START_ADDR` and `instr_count` = 0 next cycle.
- Force PC 0xFFFFFFFF by absolute jump, then step once → PC 0x00000000. Offset −1 at PC 0 → 0xFFFFFFFF.
- Assert `reset` asynchronously mid-RUN at PC 0x42 → outputs read 0 and IDLE before the next edge. `start` pulses during RUN are ignored.
